// File: rtl/fp_norm_pkg.sv
// Shared constants, flag indices and packed result layout for the fp_norm_pipe normalizer.
package fp_norm_pkg;

   localparam int EXP_WIDTH_DEF  = 5;
   localparam int MANT_WIDTH_DEF = 10;
   localparam int EXP_BIAS       = (1 << (EXP_WIDTH_DEF - 1)) - 1;
   localparam int EXP_MAX        = (1 << EXP_WIDTH_DEF) - 1;

   localparam int FLAG_OF = 1;
   localparam int FLAG_UF = 0;

   typedef struct packed {
      logic                      sign;
      logic [EXP_WIDTH_DEF-1:0]  exp;
      logic [MANT_WIDTH_DEF-1:0] frac;
   } fp_word_t;

   // Round-to-nearest-even increment decision from the kept lsb and the dropped bits.
   function automatic logic round_up(input logic lsb, input logic guard, input logic sticky);
      return guard & (sticky | lsb);
   endfunction

endpackage

// File: rtl/fp_norm_if.sv
// Input/output handshake bundle of fp_norm_pipe; slave = normalizer, master = producer/consumer.
interface fp_norm_if
   import fp_norm_pkg::*;
#(
   parameter int EXP_WIDTH  = EXP_WIDTH_DEF,
   parameter int MANT_WIDTH = MANT_WIDTH_DEF
);

   localparam int DATA_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH;

   logic                    in_valid;
   logic                    in_ready;
   logic                    in_sign;
   logic [EXP_WIDTH-1:0]    in_exp;
   logic [MANT_WIDTH+4:0]   in_mant;
   logic                    out_valid;
   logic                    out_ready;
   logic [DATA_WIDTH-1:0]   out_data;
   logic [1:0]              out_flags;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, out_ready,
      input  in_ready, out_valid, out_data, out_flags
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, out_ready,
      output in_ready, out_valid, out_data, out_flags
   );

endinterface

// File: rtl/fp_norm_pipe_lzc.sv
// Combinational leading-zero counter; an all-zero vector reports WIDTH.
module fp_lzc
   import fp_norm_pkg::*;
#(
   parameter int WIDTH     = 15,
   parameter int CNT_WIDTH = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0]     vec,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic                 zero
);

   assign zero = ~|vec;

   // Highest set bit wins because the scan runs upward and overwrites.
   always_comb begin
      cnt = CNT_WIDTH'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         cnt = vec[i] ? CNT_WIDTH'(WIDTH - 1 - i) : cnt;
      end
   end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage FP normalizer with valid/ready backpressure, zero handling and OF/UF saturation.
// Define NORM_ROUND_EN for round-to-nearest-even; otherwise the result is truncated.
module fp_norm_pipe
   import fp_norm_pkg::*;
#(
   parameter int EXP_WIDTH  = EXP_WIDTH_DEF,
   parameter int MANT_WIDTH = MANT_WIDTH_DEF,
   parameter int DATA_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH
) (
   input  logic     clk,
   input  logic     rst,
   fp_norm_if.slave bus
);

   localparam int W   = MANT_WIDTH + 5;
   localparam int CW  = $clog2(W + 1);
   localparam int EW2 = EXP_WIDTH + 2;
   localparam logic signed [EW2-1:0] EXP_ZERO = EW2'(0);
   localparam logic signed [EW2-1:0] EXP_SAT  = EW2'((1 << EXP_WIDTH) - 1);
`ifdef NORM_ROUND_EN
   localparam logic ROUND_EN = 1'b1;
`else
   localparam logic ROUND_EN = 1'b0;
`endif

   logic [CW-1:0]          lzc_cnt;
   logic                   lzc_zero;
   logic                   in_ready_s;
   logic                   s1_load;
   logic                   s2_free;
   logic                   s2_load;
   logic [CW-1:0]          lshift_s;
   logic signed [EW2-1:0]  in_exp_ext;

   logic                   s1_valid_q, s1_valid_d;
   logic                   s1_sign_q,  s1_sign_d;
   logic [W-2:0]           s1_mant_q,  s1_mant_d;
   logic                   s1_rshift_q, s1_rshift_d;
   logic [CW-1:0]          s1_lshift_q, s1_lshift_d;
   logic signed [EW2-1:0]  s1_exp_q,   s1_exp_d;
   logic                   s1_zero_q,  s1_zero_d;

   logic [W-3:0]           grs;
   logic [MANT_WIDTH-1:0]  frac;
   logic [MANT_WIDTH-1:0]  frac_rnd;
   logic                   round_inc;
   logic                   rnd_carry;
   logic signed [EW2-1:0]  exp_fin;

   logic                   s2_valid_q, s2_valid_d;
   logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
   logic [1:0]             out_flags_q, out_flags_d;

   fp_lzc #(.WIDTH(W), .CNT_WIDTH(CW)) u_lzc (
      .vec  (bus.in_mant),
      .cnt  (lzc_cnt),
      .zero (lzc_zero)
   );

   assign s2_free       = ~s2_valid_q | bus.out_ready;
   assign in_ready_s    = ~s1_valid_q | s2_free;
   assign s1_load       = bus.in_valid & in_ready_s;
   assign s2_load       = s1_valid_q & s2_free;
   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_flags = out_flags_q;

   // Stage 1 next state: classify the shift and pre-adjust the exponent.
   always_comb begin
      in_exp_ext  = $signed({2'b00, bus.in_exp});
      lshift_s    = lzc_cnt - CW'(1);
      s1_sign_d   = s1_sign_q;
      s1_mant_d   = s1_mant_q;
      s1_rshift_d = s1_rshift_q;
      s1_lshift_d = s1_lshift_q;
      s1_exp_d    = s1_exp_q;
      s1_zero_d   = s1_zero_q;
      if (in_ready_s) begin
         s1_valid_d = bus.in_valid;
      end else begin
         s1_valid_d = s1_valid_q;
      end
      if (s1_load) begin
         s1_sign_d = bus.in_sign;
         s1_mant_d = bus.in_mant[W-2:0];
         s1_zero_d = lzc_zero;
         if (bus.in_mant[W-1]) begin
            s1_rshift_d = 1'b1;
            s1_lshift_d = CW'(0);
            s1_exp_d    = in_exp_ext + EW2'(1);
         end else begin
            s1_rshift_d = 1'b0;
            s1_lshift_d = lshift_s;
            s1_exp_d    = in_exp_ext - $signed(EW2'(lshift_s));
         end
      end else begin
         s1_sign_d = s1_sign_q;
      end
   end

   // Stage 1 register.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_mant_q   <= '0;
         s1_rshift_q <= 1'b0;
         s1_lshift_q <= '0;
         s1_exp_q    <= '0;
         s1_zero_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_mant_q   <= s1_mant_d;
         s1_rshift_q <= s1_rshift_d;
         s1_lshift_q <= s1_lshift_d;
         s1_exp_q    <= s1_exp_d;
         s1_zero_q   <= s1_zero_d;
      end
   end

   // Stage 2 next state: shift, round, then saturate or flush and pack.
   always_comb begin
      // grs holds {fraction, G, R, S} once the hidden bit is in place; the carry path folds R into S.
      if (s1_rshift_q) begin
         grs = {s1_mant_q[W-2:2], s1_mant_q[1] | s1_mant_q[0]};
      end else begin
         grs = (W-2)'(s1_mant_q << s1_lshift_q);
      end
      frac        = grs[W-3:3];
      round_inc   = ROUND_EN & round_up(frac[0], grs[2], grs[1] | grs[0]);
      frac_rnd    = frac + MANT_WIDTH'(round_inc);
      rnd_carry   = round_inc & (&frac);
      exp_fin     = s1_exp_q + $signed(EW2'(rnd_carry));
      out_data_d  = out_data_q;
      out_flags_d = out_flags_q;
      if (s2_free) begin
         s2_valid_d = s1_valid_q;
      end else begin
         s2_valid_d = s2_valid_q;
      end
      if (s2_load) begin
         out_flags_d = 2'b00;
         if (s1_zero_q) begin
            out_data_d = {s1_sign_q, {(DATA_WIDTH-1){1'b0}}};
         end else if (exp_fin <= EXP_ZERO) begin
            out_data_d           = {s1_sign_q, {(DATA_WIDTH-1){1'b0}}};
            out_flags_d[FLAG_UF] = 1'b1;
         end else if (exp_fin >= EXP_SAT) begin
            out_data_d           = {s1_sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            out_flags_d[FLAG_OF] = 1'b1;
         end else begin
            out_data_d = {s1_sign_q, exp_fin[EXP_WIDTH-1:0], frac_rnd};
         end
      end else begin
         out_data_d = out_data_q;
      end
   end

   // Stage 2 register driving the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q  <= 1'b0;
         out_data_q  <= '0;
         out_flags_q <= 2'b00;
      end else begin
         s2_valid_q  <= s2_valid_d;
         out_data_q  <= out_data_d;
         out_flags_q <= out_flags_d;
      end
   end

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Self-checking bench for fp_norm_pipe (FP16 defaults): vector table, scoreboard, backpressure and reset sequences.
module tb_fp_norm_pipe;

   typedef struct {
      logic        sign;
      logic [4:0]  exp;
      logic [14:0] mant;
      logic [15:0] data;
      logic [1:0]  flags;
      string       tag;
   } vec_t;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  flags;
      int          acc;
      string       tag;
   } sb_t;

   localparam int NVEC = 13;

   logic clk = 1'b0;
   logic rst;

   vec_t        vecs [NVEC];
   sb_t         sb [$];
   sb_t         e;
   logic [15:0] cur_data;
   logic [1:0]  cur_flags;
   string       cur_tag;
   bit          lat_chk;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_out    = 0;
   int          cyc      = 0;

   fp_norm_if #(.EXP_WIDTH(5), .MANT_WIDTH(10)) bus ();

   fp_norm_pipe #(.EXP_WIDTH(5), .MANT_WIDTH(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: push on accept, pop and compare on emit.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_unexpected: got data 0x%0h flags %b, expected no output", bus.out_data, bus.out_flags);
            end else begin
               e = sb.pop_front();
               check({e.tag, "_data_flags"}, {14'd0, bus.out_flags, bus.out_data}, {14'd0, e.flags, e.data});
               if (lat_chk) check({e.tag, "_latency"}, 32'(cyc - e.acc), 32'd2);
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            sb.push_back('{data: cur_data, flags: cur_flags, acc: cyc, tag: cur_tag});
         end
      end
   end

   task automatic present(input int idx);
      bus.in_valid = 1'b1;
      bus.in_sign  = vecs[idx].sign;
      bus.in_exp   = vecs[idx].exp;
      bus.in_mant  = vecs[idx].mant;
      cur_data     = vecs[idx].data;
      cur_flags    = vecs[idx].flags;
      cur_tag      = vecs[idx].tag;
   endtask

   task automatic send(input int first, input int n);
      int   k = 0;
      int   c = 0;
      logic acc;
      while (k < n && c < 4 * n + 20) begin
         present(first + k);
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         if (acc) k++;
         c++;
      end
      bus.in_valid = 1'b0;
      check("send_accepted", 32'(k), 32'(n));
   endtask

   task automatic wait_drain(input int budget);
      int c = 0;
      while (sb.size() != 0 && c < budget) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   k;
      int   out_before;
      logic acc;
      logic presented;

      vecs[0]  = '{sign: 1'b0, exp: 5'd15, mant: 15'b0_1_0000000000_000, data: 16'h3C00, flags: 2'b00, tag: "normal"};
      vecs[1]  = '{sign: 1'b0, exp: 5'd15, mant: 15'b1_0_0000000000_000, data: 16'h4000, flags: 2'b00, tag: "carry"};
      vecs[2]  = '{sign: 1'b1, exp: 5'd15, mant: 15'b1_0_0000000000_000, data: 16'hC000, flags: 2'b00, tag: "carry_neg"};
      vecs[3]  = '{sign: 1'b0, exp: 5'd15, mant: 15'b0_0_0001000000_000, data: 16'h2C00, flags: 2'b00, tag: "lshift"};
`ifdef NORM_ROUND_EN
      vecs[4]  = '{sign: 1'b0, exp: 5'd15, mant: 15'b0_1_0000000001_100, data: 16'h3C02, flags: 2'b00, tag: "round_odd"};
      vecs[9]  = '{sign: 1'b0, exp: 5'd15, mant: 15'b0_1_1111111111_110, data: 16'h4000, flags: 2'b00, tag: "round_carry"};
      vecs[10] = '{sign: 1'b0, exp: 5'd15, mant: 15'b1_1_0000000001_011, data: 16'h4201, flags: 2'b00, tag: "carry_sticky"};
`else
      vecs[4]  = '{sign: 1'b0, exp: 5'd15, mant: 15'b0_1_0000000001_100, data: 16'h3C01, flags: 2'b00, tag: "round_odd"};
      vecs[9]  = '{sign: 1'b0, exp: 5'd15, mant: 15'b0_1_1111111111_110, data: 16'h3FFF, flags: 2'b00, tag: "round_carry"};
      vecs[10] = '{sign: 1'b0, exp: 5'd15, mant: 15'b1_1_0000000001_011, data: 16'h4200, flags: 2'b00, tag: "carry_sticky"};
`endif
      vecs[5]  = '{sign: 1'b0, exp: 5'd15, mant: 15'b0_1_0000000000_100, data: 16'h3C00, flags: 2'b00, tag: "round_tie"};
      vecs[6]  = '{sign: 1'b0, exp: 5'd30, mant: 15'b1_1_0000000000_000, data: 16'h7C00, flags: 2'b10, tag: "overflow"};
      vecs[7]  = '{sign: 1'b1, exp: 5'd3,  mant: 15'b0_0_0000000001_000, data: 16'h8000, flags: 2'b01, tag: "underflow"};
      vecs[8]  = '{sign: 1'b0, exp: 5'd20, mant: 15'b0_0_0000000000_000, data: 16'h0000, flags: 2'b00, tag: "zero"};
      vecs[11] = '{sign: 1'b0, exp: 5'd1,  mant: 15'b0_0_1000000000_000, data: 16'h0000, flags: 2'b01, tag: "uf_exp0"};
      vecs[12] = '{sign: 1'b0, exp: 5'd30, mant: 15'b0_1_1111111111_000, data: 16'h7BFF, flags: 2'b00, tag: "max_normal"};

      bus.in_valid  = 1'b0;
      bus.in_sign   = 1'b0;
      bus.in_exp    = 5'd0;
      bus.in_mant   = 15'd0;
      bus.out_ready = 1'b1;
      cur_data      = 16'h0000;
      cur_flags     = 2'b00;
      cur_tag       = "none";
      lat_chk       = 1'b0;
      rst           = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset_out_data", {16'd0, bus.out_data}, 32'd0);
      check("reset_out_flags", {30'd0, bus.out_flags}, 32'd0);
      check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;

      lat_chk = 1'b1;
      for (int i = 0; i < NVEC; i++) begin
         send(i, 1);
         wait_drain(10);
      end
      send(0, NVEC);
      wait_drain(10);
      lat_chk = 1'b0;

      // Backpressure: only two words fit while the output is blocked.
      bus.out_ready = 1'b0;
      k   = 0;
      acc = 1'b1;
      for (int c = 0; c < 6; c++) begin
         present(k);
         @(negedge clk);
         acc = bus.in_ready;
         if (c >= 2) begin
            check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_hold_data", {16'd0, bus.out_data}, {16'd0, vecs[0].data});
         end
         @(posedge clk);
         #1;
         if (acc) k++;
      end
      check("bp_accepted", 32'(k), 32'd2);
      check("bp_in_ready_low", {31'd0, acc}, 32'd0);

      bus.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (k < 4) begin
            present(k);
         end else begin
            bus.in_valid = 1'b0;
         end
         presented = bus.in_valid;
         @(negedge clk);
         acc = bus.in_ready;
         check("bp_no_bubble", {31'd0, bus.out_valid}, 32'd1);
         @(posedge clk);
         #1;
         if (acc && presented) k++;
      end
      bus.in_valid = 1'b0;
      check("bp_all_sent", 32'(k), 32'd4);
      wait_drain(10);

      // Reset with two words in flight discards them.
      bus.out_ready = 1'b0;
      send(4, 2);
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      out_before    = n_out;
      repeat (6) @(posedge clk);
      #1;
      check("rst_no_stale", 32'(n_out - out_before), 32'd0);

      lat_chk = 1'b1;
      send(6, 1);
      wait_drain(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_norm_pipe.md
# fp_norm_pipe

Parametrised, pipelined floating-point normalizer with a valid/ready handshake, sitting between the systolic-array accumulate adder and the result writeback path. It takes a signed, unnormalized {sign, biased exponent, extended mantissa with carry, hidden and guard bits} and produces a packed IEEE-style word (sign, exponent, fraction). Compared with the earlier combinational FP16 normalizer, it adds:

- handling of the adder carry-out (right shift);
- sign pass-through;
- zero handling;
- overflow/underflow saturation with flags;
- optional round-to-nearest-even;
- a two-stage pipeline with backpressure.

## Interface

Parameters:
- EXP_WIDTH, 5, exponent field width (biased, bias = 2^(EXP_WIDTH-1)-1)
- MANT_WIDTH, 10, stored fraction width
- DATA_WIDTH, 1+EXP_WIDTH+MANT_WIDTH, packed output width (derived; do not override)

Ports:
- clk  in  1  clock; single clock domain; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts input this cycle
- in_sign  in  1  sign, passed through unchanged
- in_exp  in  EXP_WIDTH  biased exponent of the unnormalized value
- in_mant  in  MANT_WIDTH+5  {carry, hidden, fraction[MANT_WIDTH-1:0], G, R, S}
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts output
- out_data  out  DATA_WIDTH  {sign, exp, fraction}
- out_flags  out  2  bit 1 = overflow (saturated to infinity), bit 0 = underflow (flushed to zero)

## Operation

Stage 1 (register S1):
- Leading-zero count over {carry, hidden, fraction, G, R, S}.
- Carry set: shift right 1; S' = S|R; exp_adj = in_exp+1.
- Otherwise: shift left by lzc-1; exp_adj = in_exp-(lzc-1).
- Arithmetic is signed, EXP_WIDTH+2 bits.
- Mantissa all zero: zero flag set, exponent ignored.

Stage 2 (register S2):
- Apply the shift.
- Round (see Configuration).
- Rounding carry-out (fraction all ones + 1): fraction = 0, exp_adj+1.
- Pack the result.

Results:
- Zero mantissa: out_data = {sign, 0, 0}, flags = 0.
- exp_adj <= 0 after rounding: flush to {sign, 0, 0}, underflow = 1. No subnormals are generated.
- exp_adj >= 2^EXP_WIDTH-1: saturate to {sign, all ones, 0}, overflow = 1.

## Timing

- Latency is 2 cycles from accepted input (in_valid & in_ready) to out_valid, with no stall.
- Throughput is 1 word per cycle.
- Handshake:
  - Each stage advances when it is empty or the next stage advances.
  - in_ready = ~S1.valid | S1 advance, combinational; there is no combinational path from in_valid.
  - out_valid and out_data stay stable while out_valid & ~out_ready.
  - The pipeline holds at most 2 words.
  - Words leave in acceptance order.
- Reset:
  - rst clears the S1 and S2 valid bits, out_data, and out_flags to 0.
  - in_ready reads 1 from the first cycle after reset.
  - Reset mid-operation discards in-flight words with no output.
- Simultaneous accept and emit in the same cycle is required with no bubble.

## Configuration

- NORM_ROUND_EN defined:
  - Round-to-nearest-even using G, R|S: increment when G & (R|S|lsb).
  - Can cause overflow via rounding carry.
- NORM_ROUND_EN undefined:
  - Truncate; G, R, S are ignored after the shift.
  - Overflow only from the carry path.

## Structure

- Package fp_norm_pkg holds:
  - default EXP_WIDTH and MANT_WIDTH;
  - bias and EXP_MAX localparams;
  - flag bit indices (FLAG_OF=1, FLAG_UF=0);
  - the packed-field typedef for {sign, exp, fraction}.
- Sub-module fp_lzc: parametrised leading-zero counter, combinational, width MANT_WIDTH+5, output clog2 width. It is instantiated in stage 1.

## Test plan

Defaults (FP16) throughout.

- Normal: sign 0, exp 15, mant 0_1_0000000000_000 -> 0x3C00 exactly 2 cycles later, flags 00.
- Carry: exp 15, mant 1_0_0000000000_000 -> 0x4000. With sign 1 -> 0xC000.
- Left shift: exp 15, mant 0_0_0001000000_000 -> 0x2C00 (exp 11).
- Rounding: exp 15, mant 0_1_0000000001_100.
  - With NORM_ROUND_EN -> 0x3C02.
  - Without -> 0x3C01.
  - Mant 0_1_0000000000_100 -> 0x3C00 in both builds (tie, even).
- Limits:
  - exp 30, mant 1_1_0000000000_000 -> 0x7C00, flags 10.
  - sign 1, exp 3, mant 0_0_0000000001_000 -> 0x8000, flags 01.
  - Zero mantissa, exp 20 -> 0x0000, flags 00.
- Backpressure/reset:
  - Hold out_ready = 0 and drive 4 back-to-back words -> in_ready drops after 2 accepted, output held stable.
  - Release out_ready -> all words emerge in order with no bubble.
  - Assert rst with 2 words in flight -> out_valid = 0 next cycle, no stale word emitted.
